// File: rtl/shift_piso_tx_pkg.sv
// Shared constants for the PISO serial transmitter: FSM state encoding and
// the default line level driven between words.
package shift_piso_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic IDLE_LEVEL_DEF = 1'b0;

endpackage

// File: rtl/Shift_SIPO.sv
// Serial-in/parallel-out receiver: samples s_in on negedge, LSB arrives first,
// so after WIDTH samples q_out holds the transmitted word in natural order.
module Shift_SIPO #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    output logic [WIDTH-1:0] q_out
);

    // New bits enter at the MSB, so the first (LSB) bit ends up at q_out[0].
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            q_out <= '0;
        end else begin
            q_out <= {s_in, q_out[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_piso_tx.sv
// Parallel-in/serial-out transmitter: sends a WIDTH-bit word LSB first, one bit
// per clk, with ready/busy/done handshaking for gapless back-to-back streaming.
module shift_piso_tx
    import shift_piso_tx_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] p_in,
    output logic             ready,
    output logic             busy,
    output logic             s_out,
    output logic             done
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sh_reg;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;

    assign last_bit = (cnt == LAST);
    assign busy     = (state == ST_SHIFT);
    // Reset holds state at IDLE, so ready is masked explicitly while it is high.
    assign ready    = !reset && (!busy || last_bit);
    assign s_out    = busy ? sh_reg[0] : IDLE_LEVEL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            sh_reg <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            // NOTE: non-blocking default; a later assignment in this block wins,
            // giving a single-cycle done pulse without a separate clear path.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state  <= ST_SHIFT;
                        sh_reg <= p_in;
                        cnt    <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (!last_bit) begin
                        sh_reg <= sh_reg >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end else begin
                        done <= 1'b1;
                        if (load) begin
                            sh_reg <= p_in;
                            cnt    <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
